pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: Reset_L  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: NextPC  input  32  next PC from the next-PC logic, sampled only on a decode handshake.
REQ-005 SHALL have ports: IMemReq  output  1 and IMemAddr  output  32; instruction-memory request and word address.
REQ-006 SHALL have port: IMemGnt  input  1  memory accepts the request this cycle.
REQ-007 SHALL have ports: IMemRvalid  input  1 and IMemRdata  input  32; read response.
REQ-008 SHALL have ports: Instr  output  32 and CurrentPC  output  32; fetched instruction and its PC, also fed to the next-PC logic.
REQ-009 SHALL have ports: InstrValid  output  1 and InstrReady  input  1; decode handshake.
REQ-010 SHALL have port: FetchFault  output  1  sticky misaligned-PC flag (see Configuration).

Function
REQ-011 SHALL implement FSM IDLE, FETCH, WAIT, VALID, FAULT, with exactly one request outstanding at a time.
REQ-012 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-013 FETCH SHALL assert IMemReq with IMemAddr=CurrentPC, holding both stable until IMemGnt=1, then go to WAIT.
REQ-014 IMemGnt SHALL be allowed high in the same cycle IMemReq rises (zero-wait grant).
REQ-015 IMemRvalid SHALL be ignored in every state except WAIT.
REQ-016 WAIT SHALL capture IMemRdata into Instr on IMemRvalid=1 and go to VALID, giving minimum latency of request to InstrValid of 2 cycles.
REQ-017 VALID SHALL hold InstrValid=1 with Instr and CurrentPC stable until InstrReady=1.
REQ-018 On InstrValid&InstrReady, the block SHALL load CurrentPC<=NextPC and go to FETCH; InstrReady while InstrValid=0 SHALL have no effect.
REQ-019 CurrentPC SHALL change only on reset or the REQ-018 handshake.
REQ-020 PC arithmetic SHALL be 32-bit with no overflow detection: NextPC is loaded verbatim, including wrap from 32'hFFFFFFFC to 0.
REQ-021 IMemReq and InstrValid SHALL be registered outputs, never combinational from inputs.

Reset
REQ-022 Reset_L=0 SHALL immediately force state=IDLE, CurrentPC=RESET_PC, Instr=0, InstrValid=0, IMemReq=0, IMemAddr=RESET_PC, and FetchFault=0.
REQ-023 Reset mid-operation SHALL abandon any outstanding request; the instruction memory shares Reset_L and SHALL drop pending responses.
REQ-024 After Reset_L deasserts, the first IMemReq SHALL appear on the second rising edge, via IDLE then FETCH.

Configuration
REQ-025 Macro FETCH_ALIGN_CHECK_EN defined: on entering FETCH with CurrentPC[1:0]!=0, the block SHALL go to FAULT instead of requesting.
REQ-026 FAULT SHALL set FetchFault=1, hold IMemReq=0 and InstrValid=0, and be left only by reset.
REQ-027 Macro FETCH_ALIGN_CHECK_EN undefined: there SHALL be no alignment check, FAULT SHALL be unreachable, FetchFault SHALL be tied 0, and IMemAddr SHALL be CurrentPC unmodified.

Structure
REQ-028 Package fetch_pkg SHALL hold the FSM state typedef, the default RESET_PC constant, and the word-alignment mask constant.
REQ-029 Sub-module pc_register SHALL be used: a 32-bit load-enable register with async active-low reset to RESET_PC, holding CurrentPC.

Verification
REQ-030 Reset then release with IMemGnt=1 and Rvalid one cycle after grant SHALL give IMemReq=1, IMemAddr=0 on the 2nd edge and InstrValid=1, CurrentPC=0 two cycles later.
REQ-031 CurrentPC=0x10 and NextPC=0x14 with InstrReady=1 SHALL give CurrentPC=0x14 and a new request with IMemAddr=0x14.
REQ-032 IMemGnt held 0 for 5 cycles SHALL keep IMemReq=1 and IMemAddr=0x10 stable; Rvalid pulses during those cycles SHALL be ignored.
REQ-033 InstrReady held 0 for 4 cycles in VALID SHALL keep Instr, CurrentPC and InstrValid unchanged, and NextPC=0xF0000000 on the handshake SHALL give CurrentPC=0xF0000000.
REQ-034 Reset_L pulsed low while in WAIT SHALL give CurrentPC=RESET_PC and InstrValid=0 immediately, and a late Rvalid SHALL be ignored.
REQ-035 With FETCH_ALIGN_CHECK_EN defined, NextPC=0x13 on the handshake SHALL give FetchFault=1 and IMemReq=0 until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [PC_W-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    FAULT = 3'd4
  } fetchState_t;

  // True when the PC points at a 32-bit word boundary.
  function automatic logic isWordAligned(input logic [PC_W-1:0] pc);
    return (pc & ~WORD_ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Load-enable program counter register with async active-low reset to RESET_PC.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic            LoadEn,
  input  logic [PC_W-1:0] D,
  output logic [PC_W-1:0] Q
);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      Q <= RESET_PC;
    end else if (LoadEn) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Single-outstanding instruction fetch stage with decode handshake.
// Optional misaligned-PC fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic [PC_W-1:0] NextPC,
  output logic            IMemReq,
  output logic [PC_W-1:0] IMemAddr,
  input  logic            IMemGnt,
  input  logic            IMemRvalid,
  input  logic [PC_W-1:0] IMemRdata,
  output logic [PC_W-1:0] Instr,
  output logic [PC_W-1:0] CurrentPC,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic            FetchFault
);

  fetchState_t state;
  logic        pcLoad;

  // PC advances only on the decode handshake.
  assign pcLoad = (state == VALID) && InstrReady;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .LoadEn  (pcLoad),
    .D       (NextPC),
    .Q       (CurrentPC)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetchFaultQ;
  assign FetchFault = fetchFaultQ;
`else
  assign FetchFault = 1'b0;
`endif

  // FETCH spends one cycle with IMemReq low to launch the request, then holds it until granted.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state      <= IDLE;
      IMemReq    <= 1'b0;
      IMemAddr   <= RESET_PC;
      Instr      <= '0;
      InstrValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetchFaultQ <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (!IMemReq) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (!isWordAligned(CurrentPC)) begin
              state       <= FAULT;
              fetchFaultQ <= 1'b1;
            end else begin
              IMemReq  <= 1'b1;
              IMemAddr <= CurrentPC;
            end
`else
            IMemReq  <= 1'b1;
            IMemAddr <= CurrentPC;
`endif
          end else if (IMemGnt) begin
            IMemReq <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (IMemRvalid) begin
            Instr      <= IMemRdata;
            InstrValid <= 1'b1;
            state      <= VALID;
          end
        end
        VALID: begin
          if (InstrReady) begin
            InstrValid <= 1'b0;
            state      <= FETCH;
          end
        end
        FAULT: begin
          IMemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage; define FETCH_ALIGN_CHECK_EN to cover the fault path.
module tb_pc_fetch_stage;

  logic        CLK;
  logic        Reset_L;
  logic [31:0] NextPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRvalid;
  logic [31:0] IMemRdata;
  logic [31:0] Instr;
  logic [31:0] CurrentPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        FetchFault;

  int total = 0;
  int bad   = 0;

  pc_fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .NextPC     (NextPC),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemGnt    (IMemGnt),
    .IMemRvalid (IMemRvalid),
    .IMemRdata  (IMemRdata),
    .Instr      (Instr),
    .CurrentPC  (CurrentPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .FetchFault (FetchFault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // From FETCH with IMemReq low: issue, get granted, receive data one cycle after grant.
  task automatic doFetch(input logic [31:0] pc, input logic [31:0] data);
    tick();
    chk("req_up", 32'(IMemReq), 32'd1);
    chk("req_addr", IMemAddr, pc);
    tick();
    chk("req_drop", 32'(IMemReq), 32'd0);
    IMemRvalid = 1'b1;
    IMemRdata  = data;
    tick();
    IMemRvalid = 1'b0;
    chk("valid_up", 32'(InstrValid), 32'd1);
    chk("instr", Instr, data);
    chk("valid_pc", CurrentPC, pc);
  endtask

  task automatic handshake(input logic [31:0] npc);
    NextPC     = npc;
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
    chk("hs_pc", CurrentPC, npc);
    chk("hs_valid_drop", 32'(InstrValid), 32'd0);
  endtask

  initial begin
    Reset_L    = 1'b0;
    NextPC     = '0;
    IMemGnt    = 1'b0;
    IMemRvalid = 1'b0;
    IMemRdata  = '0;
    InstrReady = 1'b0;
    #3;
    chk("rst_req", 32'(IMemReq), 32'd0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_pc", CurrentPC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_fault", 32'(FetchFault), 32'd0);
    tick();
    tick();

    // Release with grant held high; first request on second edge.
    Reset_L = 1'b1;
    IMemGnt = 1'b1;
    tick();
    chk("idle_noreq", 32'(IMemReq), 32'd0);
    doFetch(32'h0, 32'hAAAA_0001);

    // Move to PC 0x10 and stall the grant for five cycles with stray rvalid pulses.
    handshake(32'h10);
    IMemGnt = 1'b0;
    tick();
    chk("stall_req0", 32'(IMemReq), 32'd1);
    chk("stall_addr0", IMemAddr, 32'h10);
    IMemRdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      IMemRvalid = (i % 2) == 0;
      tick();
      chk("stall_req", 32'(IMemReq), 32'd1);
      chk("stall_addr", IMemAddr, 32'h10);
      chk("stall_novalid", 32'(InstrValid), 32'd0);
    end
    IMemRvalid = 1'b0;
    IMemGnt    = 1'b1;
    tick();
    chk("gnt_drop", 32'(IMemReq), 32'd0);
    tick();
    chk("wait_novalid", 32'(InstrValid), 32'd0);
    IMemRvalid = 1'b1;
    IMemRdata  = 32'h0000_1111;
    tick();
    IMemRvalid = 1'b0;
    chk("late_valid", 32'(InstrValid), 32'd1);
    chk("late_instr", Instr, 32'h0000_1111);
    chk("late_pc", CurrentPC, 32'h10);

    // 0x10 -> 0x14; ready while not valid must not move the PC.
    handshake(32'h14);
    tick();
    chk("pc14_req", 32'(IMemReq), 32'd1);
    chk("pc14_addr", IMemAddr, 32'h14);
    tick();
    NextPC     = 32'h998;
    InstrReady = 1'b1;
    tick();
    chk("rdy_noeffect_pc", CurrentPC, 32'h14);
    chk("rdy_noeffect_valid", 32'(InstrValid), 32'd0);
    InstrReady = 1'b0;
    IMemRvalid = 1'b1;
    IMemRdata  = 32'h0000_2222;
    tick();
    IMemRvalid = 1'b0;
    chk("pc14_valid", 32'(InstrValid), 32'd1);

    // Back-pressure from decode for four cycles.
    NextPC = 32'hF000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 32'(InstrValid), 32'd1);
      chk("bp_instr", Instr, 32'h0000_2222);
      chk("bp_pc", CurrentPC, 32'h14);
    end
    handshake(32'hF000_0000);
    doFetch(32'hF000_0000, 32'h0000_3333);

    // Wrap from the top of the address space back to zero.
    handshake(32'hFFFF_FFFC);
    doFetch(32'hFFFF_FFFC, 32'h0000_4444);
    handshake(32'h0);
    doFetch(32'h0, 32'h0000_5555);

    // Reset while waiting for the response; late rvalid must be dropped.
    handshake(32'h40);
    tick();
    chk("pc40_addr", IMemAddr, 32'h40);
    tick();
    chk("pc40_wait", 32'(IMemReq), 32'd0);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("midrst_pc", CurrentPC, 32'h0);
    chk("midrst_valid", 32'(InstrValid), 32'd0);
    chk("midrst_req", 32'(IMemReq), 32'd0);
    chk("midrst_instr", Instr, 32'h0);
    tick();
    Reset_L    = 1'b1;
    IMemRvalid = 1'b1;
    IMemRdata  = 32'hBAD0_BAD0;
    tick();
    IMemRvalid = 1'b0;
    chk("post_rst_valid", 32'(InstrValid), 32'd0);
    chk("post_rst_noreq", 32'(IMemReq), 32'd0);
    doFetch(32'h0, 32'h0000_6666);

    // Misaligned next PC.
    handshake(32'h13);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fault_flag", 32'(FetchFault), 32'd1);
      chk("fault_noreq", 32'(IMemReq), 32'd0);
      chk("fault_novalid", 32'(InstrValid), 32'd0);
    end
    Reset_L = 1'b0;
    #1;
    chk("fault_clr", 32'(FetchFault), 32'd0);
    tick();
    Reset_L = 1'b1;
`else
    tick();
    chk("noalign_req", 32'(IMemReq), 32'd1);
    chk("noalign_addr", IMemAddr, 32'h13);
    chk("noalign_fault", 32'(FetchFault), 32'd0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
